// File: rtl/keyboard_pad_decoder.sv
// rtl/keyboard_pad_decoder.sv - PS/2 set-2 scan-code decoder driving two game pads and a start pulse
//
// Ports:
//   clk         system clock, all logic on its rising edge
//   rst         synchronous active-high reset
//   rx_data     received scan-code byte
//   rx_valid    one-cycle strobe qualifying rx_data
//   up_left     left pad up request (level)
//   down_left   left pad down request (level)
//   up_right    right pad up request (level)
//   down_right  right pad down request (level)
//   start_pulse one-cycle pulse on a fresh press of the start key

module keyboard_pad_decoder #(
  parameter logic [7:0] KEY_L_UP       = 8'h1D,
  parameter logic [7:0] KEY_L_DOWN     = 8'h1B,
  parameter logic [7:0] KEY_R_UP       = 8'h75,
  parameter logic [7:0] KEY_R_DOWN     = 8'h72,
  parameter logic [7:0] KEY_START      = 8'h29,
  parameter int         TIMEOUT_CYCLES = 650000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       up_left,
  output logic       down_left,
  output logic       up_right,
  output logic       down_right,
  output logic       start_pulse
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] tmo_cnt, tmo_cnt_next;

  logic l_up, l_down, r_up, r_down, start_held;
  logic l_up_next, l_down_next, r_up_next, r_down_next, start_held_next;
  logic start_pulse_next;

  // Decoded key event for the byte completing a sequence
  logic ev_valid, ev_ext, ev_break;
  logic is_prefix, is_noise;

  assign is_prefix = (rx_data == PFX_EXT) || (rx_data == PFX_BRK);
  // Keyboard self-test/ack/resend/error bytes that may appear between scan codes
  assign is_noise  = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hFE) ||
                     (rx_data == 8'h00) || (rx_data == 8'hFF);

  always_comb begin
    state_next   = state;
    tmo_cnt_next = tmo_cnt;
    ev_valid     = 1'b0;
    ev_ext       = 1'b0;
    ev_break     = 1'b0;

    if (rx_valid) begin
      // A byte arriving on the timeout cycle still wins: it is decoded in the current state
      tmo_cnt_next = '0;
      case (state)
        IDLE: begin
          if (rx_data == PFX_EXT) begin
            state_next = EXT;
          end else if (rx_data == PFX_BRK) begin
            state_next = BRK;
          end else if (!is_noise) begin
            ev_valid = 1'b1;
          end
        end
        EXT: begin
          if (rx_data == PFX_BRK) begin
            state_next = EXT_BRK;
          end else if (rx_data == PFX_EXT) begin
            state_next = EXT;
          end else begin
            ev_valid   = 1'b1;
            ev_ext     = 1'b1;
            state_next = IDLE;
          end
        end
        BRK: begin
          state_next = IDLE;
          if (!is_prefix) begin
            ev_valid = 1'b1;
            ev_break = 1'b1;
          end
        end
        EXT_BRK: begin
          state_next = IDLE;
          if (!is_prefix) begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
            ev_break = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (state != IDLE) begin
      // Abandon a stalled prefix sequence so a lost byte cannot corrupt the next key
      if (tmo_cnt == TMO_LAST) begin
        state_next   = IDLE;
        tmo_cnt_next = '0;
      end else begin
        tmo_cnt_next = tmo_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    l_up_next        = l_up;
    l_down_next      = l_down;
    r_up_next        = r_up;
    r_down_next      = r_down;
    start_held_next  = start_held;
    start_pulse_next = 1'b0;

    if (ev_valid) begin
      if (!ev_ext) begin
        if (rx_data == KEY_L_UP)   l_up_next   = !ev_break;
        if (rx_data == KEY_L_DOWN) l_down_next = !ev_break;
        if (rx_data == KEY_START) begin
          // Typematic repeats arrive as makes while held; only a fresh press pulses
          start_pulse_next = !ev_break && !start_held;
          start_held_next  = !ev_break;
        end
      end else begin
        if (rx_data == KEY_R_UP)   r_up_next   = !ev_break;
        if (rx_data == KEY_R_DOWN) r_down_next = !ev_break;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      l_up        <= 1'b0;
      l_down      <= 1'b0;
      r_up        <= 1'b0;
      r_down      <= 1'b0;
      start_held  <= 1'b0;
      up_left     <= 1'b0;
      down_left   <= 1'b0;
      up_right    <= 1'b0;
      down_right  <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      tmo_cnt     <= tmo_cnt_next;
      l_up        <= l_up_next;
      l_down      <= l_down_next;
      r_up        <= r_up_next;
      r_down      <= r_down_next;
      start_held  <= start_held_next;
      // Opposing keys on one pad cancel each other
      up_left     <= l_up_next & ~l_down_next;
      down_left   <= l_down_next & ~l_up_next;
      up_right    <= r_up_next & ~r_down_next;
      down_right  <= r_down_next & ~r_up_next;
      start_pulse <= start_pulse_next;
    end
  end

endmodule

// File: doc/keyboard_pad_decoder.md
KEYBOARD_PAD_DECODER -- requirements
Module: keyboard_pad_decoder

Interface
REQ-001 SHALL have parameter KEY_L_UP, default 8'h1D, set-1-less PS/2 set-2 code for left pad up (W).
REQ-002 SHALL have parameter KEY_L_DOWN, default 8'h1B, left pad down (S).
REQ-003 SHALL have parameter KEY_R_UP, default 8'h75, extended (E0-prefixed) code for right pad up (arrow up).
REQ-004 SHALL have parameter KEY_R_DOWN, default 8'h72, extended code for right pad down (arrow down).
REQ-005 SHALL have parameter KEY_START, default 8'h29, non-extended start key (space).
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 650000, max clk cycles allowed between prefix and following byte.
REQ-007 clk  input  1  system clock; all logic on posedge clk.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 rx_data  input  8  received PS/2 scan-code byte.
REQ-010 rx_valid  input  1  single-cycle strobe, rx_data valid when high.
REQ-011 up_left / down_left  output  1 each  level, left pad movement request.
REQ-012 up_right / down_right  output  1 each  level, right pad movement request.
REQ-013 start_pulse  output  1  one-cycle pulse on start key make.

Function
REQ-014 SHALL decode set-2 scan codes with FSM states IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0).
REQ-015 IDLE: rx_valid & E0 -> EXT; rx_valid & F0 -> BRK; rx_valid & other byte -> make event for non-extended code, stay IDLE.
REQ-016 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> extended make event, -> IDLE.
REQ-017 BRK: any non-prefix byte -> non-extended break event, -> IDLE; E0 or F0 in BRK -> IDLE, no event.
REQ-018 EXT_BRK: non-prefix byte -> extended break event, -> IDLE; prefix byte -> IDLE, no event.
REQ-019 SHALL keep four held-key flags (l_up, l_down, r_up, r_down): make of matching code sets flag, break clears it; codes match only with correct extended/non-extended class.
REQ-020 Repeated make (typematic) of a held key SHALL leave flag set, no other effect.
REQ-021 Bytes 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF in IDLE SHALL be ignored.
REQ-022 Outputs SHALL be registered: up_left = l_up & ~l_down, down_left = l_down & ~l_up; right side identical; both keys held -> both outputs 0.
REQ-023 Output latency SHALL be 1 cycle: output changes on cycle after the rx_valid of the final byte of the sequence.
REQ-024 start_pulse SHALL be high exactly one cycle, 1 cycle after non-extended KEY_START make; not on typematic repeat while start held (track start-held flag, cleared on break).
REQ-025 Timeout counter SHALL count clk cycles while in EXT, BRK or EXT_BRK, cleared on every rx_valid; reaching TIMEOUT_CYCLES-1 SHALL force IDLE with no event; width = $clog2(TIMEOUT_CYCLES).
REQ-026 rx_valid coinciding with timeout cycle SHALL take priority; byte processed normally.
REQ-027 Left and right flags SHALL be independent; simultaneous holds on both sides produce both outputs.

Reset
REQ-028 rst SHALL force state IDLE, timeout counter 0, all held flags 0, all outputs 0, start_pulse 0.
REQ-029 rst mid-sequence (e.g. after E0) SHALL discard the partial sequence; next byte decoded from IDLE.
REQ-030 rst SHALL take priority over rx_valid in the same cycle.

Verification
REQ-031 Bytes 1D, then F0 1D -> up_left=1 one cycle after 1D, up_left=0 one cycle after second 1D; down_left stays 0.
REQ-032 Bytes E0 72, then E0 F0 72 -> down_right 1 after 72, 0 after final 72; plain 72 (no E0) -> down_right unchanged.
REQ-033 1D then 1B held -> up_left=1 then both up_left and down_left 0; F0 1D -> down_left=1.
REQ-034 29, 29, 29 (typematic), F0 29, 29 -> start_pulse exactly twice, each one cycle wide.
REQ-035 E0 then no byte for TIMEOUT_CYCLES (bench with TIMEOUT_CYCLES=16) -> FSM IDLE; next byte 75 treated non-extended -> up_right stays 0.
REQ-036 1D, rst pulse, F0 then 1D -> all outputs 0 after rst and remain 0.
